// File: rtl/braille_pkg.sv
// Shared constants and types for the Braille key front end and its consumers.
package braille_pkg;

  // Six dot keys; bit 0 is dot 1. Downstream compare logic sizes its
  // pattern registers from this constant.
  localparam int BRAILLE_NKEYS = 6;

  // Default debounce window in 1 ms ticks.
  localparam int BRAILLE_DEB_MS = 20;

  // Counter width that comfortably holds the default window.
  localparam int BRAILLE_CNT_W = 5;

  // Chord capture FSM states.
  typedef enum logic [0:0] {
    CH_IDLE    = 1'b0,
    CH_COLLECT = 1'b1
  } chord_state_e;

  // Encoded state values for consumers that only see the raw debug bit.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser (inverting the active-low key),
// a tick counter that must see DEB_MS uninterrupted 1 ms ticks before a
// level change is accepted, and a mismatch flag used to run the timer.
module key_debounce_ch #(
  parameter int DEB_MS = 20,
  parameter int CNT_W  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic tick_1ms,
  output logic stable,
  output logic mismatch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_MS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchronise, then count ticks while the synchronised level
  // disagrees with the accepted level. Agreement clears the count even on a
  // tick, so any bounce back restarts the window.
  always_comb begin
    sync1_d  = ~key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (tick_1ms) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Channel registers; synchroniser resets to the released level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable   = stable_q;
  assign mismatch = sync2_q ^ stable_q;

endmodule

// File: rtl/braille_key_debounce.sv
// Debounce for the six Braille dot keys plus chord capture.
// A chord is the OR of every key level seen from the first accepted press
// until all keys are accepted as released.
//
// Handshake: chord is stable whenever chord_valid = 1. chord_valid stays
// high until a cycle with chord_ack = 1; it drops on the following edge
// unless a new chord completes in that same cycle, in which case the new
// chord replaces the old one and chord_valid stays high. A chord completing
// while the previous one is pending and unacknowledged is dropped and
// signalled by a one-cycle overrun pulse. chord_ack with chord_valid = 0 has
// no effect.
module braille_key_debounce
  import braille_pkg::*;
#(
  parameter int NKEYS  = BRAILLE_NKEYS,
  parameter int DEB_MS = BRAILLE_DEB_MS,
  parameter int CNT_W  = BRAILLE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_n,
  input  logic             tick_1ms,
  output logic             tick_en,
  output logic [NKEYS-1:0] key_state,
  output logic [NKEYS-1:0] chord,
  output logic             chord_valid,
  input  logic             chord_ack,
  output logic             overrun,
  output logic             fsm_state_dbg
);

  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] mismatch;

  for (genvar g = 0; g < NKEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEB_MS (DEB_MS),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_n    (key_n[g]),
      .tick_1ms (tick_1ms),
      .stable   (stable[g]),
      .mismatch (mismatch[g])
    );
  end

  assign key_state = stable;

  // ---------------------------------------------------------------------
  // Timer enable: registered OR of all channel mismatches.
  // ---------------------------------------------------------------------
  logic tick_en_q, tick_en_d;

  // Timer runs whenever any channel has an unresolved level change.
  always_comb begin
    tick_en_d = |mismatch;
  end

  // Timer enable register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_en_q <= 1'b0;
    end else begin
      tick_en_q <= tick_en_d;
    end
  end

  assign tick_en = tick_en_q;

  // ---------------------------------------------------------------------
  // Chord FSM: IDLE waits for any held key, COLLECT ORs key levels until
  // all keys are released, then fires a completion event.
  // ---------------------------------------------------------------------
  chord_state_e     state_q, state_d;
  logic [NKEYS-1:0] accum_q, accum_d;
  logic             done;

  // FSM next-state and accumulator update.
  always_comb begin
    state_d = state_q;
    accum_d = accum_q;
    done    = 1'b0;
    case (state_q)
      CH_IDLE: begin
        accum_d = '0;
        if (|stable) begin
          state_d = CH_COLLECT;
          accum_d = stable;
        end
      end
      CH_COLLECT: begin
        if (stable == '0) begin
          state_d = CH_IDLE;
          accum_d = '0;
          done    = 1'b1;
        end else begin
          accum_d = accum_q | stable;
        end
      end
      default: begin
        state_d = CH_IDLE;
        accum_d = '0;
      end
    endcase
  end

  // FSM registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CH_IDLE;
      accum_q <= '0;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;
    end
  end

  assign fsm_state_dbg = state_q;

  // ---------------------------------------------------------------------
  // Output holding register and handshake.
  // ---------------------------------------------------------------------
  logic [NKEYS-1:0] chord_q, chord_d;
  logic             chord_valid_q, chord_valid_d;
  logic             overrun_q, overrun_d;

  // Completion loads the holding register if it is free or being freed this
  // cycle; otherwise the new chord is lost and overrun pulses.
  always_comb begin
    chord_d       = chord_q;
    chord_valid_d = chord_valid_q;
    overrun_d     = 1'b0;
    if (done) begin
      if (!chord_valid_q || chord_ack) begin
        chord_d       = accum_q;
        chord_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (chord_ack && chord_valid_q) begin
      chord_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chord_q       <= '0;
      chord_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      chord_q       <= chord_d;
      chord_valid_q <= chord_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign chord       = chord_q;
  assign chord_valid = chord_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_braille_key_debounce.sv
// Bench for braille_key_debounce: directed scenarios with literal
// expectations plus randomized gestures, all checked every cycle against a
// gesture-level reference model.
module tb_braille_key_debounce;

  localparam int NK       = 6;
  localparam int DEB      = 4;
  localparam int CW       = 3;
  localparam int TICK_PER = 10;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          tick_1ms = 1'b0;
  logic          chord_ack = 1'b0;
  logic          tick_en;
  logic [NK-1:0] key_state;
  logic [NK-1:0] chord;
  logic          chord_valid;
  logic          overrun;
  logic          fsm_state_dbg;

  always #5 clk = ~clk;

  braille_key_debounce #(
    .NKEYS  (NK),
    .DEB_MS (DEB),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .tick_1ms      (tick_1ms),
    .tick_en       (tick_en),
    .key_state     (key_state),
    .chord         (chord),
    .chord_valid   (chord_valid),
    .chord_ack     (chord_ack),
    .overrun       (overrun),
    .fsm_state_dbg (fsm_state_dbg)
  );

  // 1 ms tick stand-in: one pulse every TICK_PER cycles.
  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt == TICK_PER - 1) ? 0 : tcnt + 1;
      tick_1ms = (tcnt == 0);
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each key: the pressed level as seen through two clocks of delay, the
  // accepted level, and how many ticks the current disagreement has lasted.
  // Chords: a gesture is open while any accepted key is held; its pattern is
  // the union of all held keys. Finished patterns go to a one-deep holding
  // slot that the consumer empties with ack.
  bit          m_seen[NK][2];
  bit          m_acc_lvl[NK];
  int          m_ticks[NK];
  bit          m_tick_en;
  bit          m_open;
  bit [NK-1:0] m_union;
  bit [NK-1:0] m_slot;
  bit          m_slot_full;
  bit          m_ovr;
  bit          m_live = 1'b0;

  function automatic bit [NK-1:0] m_levels();
    bit [NK-1:0] v;
    for (int i = 0; i < NK; i++) v[i] = m_acc_lvl[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bit [NK-1:0] held;
    bit          any_open_change;
    held = m_levels();
    if (!rst) begin
      for (int i = 0; i < NK; i++) begin
        m_seen[i][0] = 0; m_seen[i][1] = 0; m_acc_lvl[i] = 0; m_ticks[i] = 0;
      end
      m_tick_en = 0; m_open = 0; m_union = '0; m_slot = '0;
      m_slot_full = 0; m_ovr = 0; m_live = 1'b1;
    end else begin
      m_ovr = 0;
      if (m_open && held == '0) begin
        m_open = 0;
        if (!m_slot_full || chord_ack) begin
          m_slot = m_union;
          m_slot_full = 1;
        end else begin
          m_ovr = 1;
        end
        m_union = '0;
      end else begin
        if (chord_ack) m_slot_full = 0;
        if (held != '0) begin
          m_open = 1;
          m_union = m_union | held;
        end
      end
      any_open_change = 0;
      for (int i = 0; i < NK; i++) begin
        if (m_seen[i][1] != m_acc_lvl[i]) begin
          any_open_change = 1;
          if (tick_1ms) m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] == DEB) begin
            m_acc_lvl[i] = m_seen[i][1];
            m_ticks[i] = 0;
          end
        end else begin
          m_ticks[i] = 0;
        end
        m_seen[i][1] = m_seen[i][0];
        m_seen[i][0] = !key_n[i];
      end
      m_tick_en = any_open_change;
    end
  end

  // Single compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      chk("key_state", 32'(key_state), 32'(m_levels()));
      chk("tick_en", 32'(tick_en), 32'(m_tick_en));
      chk("chord_valid", 32'(chord_valid), 32'(m_slot_full));
      chk("chord", 32'(chord), 32'(m_slot));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // ---------------- driver tasks ----------------
  int ovr_pulses = 0;
  int cv_rises   = 0;
  bit cv_prev    = 1'b0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (overrun) ovr_pulses++;
      if (chord_valid && !cv_prev) cv_rises++;
      cv_prev = chord_valid;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      if (chord_valid) ok = 1;
    end
    if (!ok) chk(name, 32'(ok), 32'd1);
  endtask

  task automatic ack_once();
    chord_ack = 1'b1;
    cyc(1);
    chord_ack = 1'b0;
    cyc(1);
    chk("ack_clears", 32'(chord_valid), 32'd0);
  endtask

  // Gesture with bounce on press and release; ack toggles randomly.
  task automatic rand_gesture();
    logic [NK-1:0] pat;
    pat = NK'($urandom_range(1, 63));
    for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
      key_n = ~(pat & NK'($urandom_range(0, 63)));
      chord_ack = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 8));
    end
    key_n = ~pat;
    for (int c = 0; c < int'($urandom_range(20, 90)); c++) begin
      chord_ack = ($urandom_range(0, 7) == 0);
      cyc(1);
    end
    for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
      key_n = ~(pat & NK'($urandom_range(0, 63)));
      cyc($urandom_range(1, 8));
    end
    key_n = '1;
    for (int c = 0; c < int'($urandom_range(0, 80)); c++) begin
      chord_ack = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    chord_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    bit          seen;
    bit          bad;
    bit          fired;
    int          base_ovr;
    int          base_rise;

    rst = 1'b0;
    cyc(3);
    chk("reset_key_state", 32'(key_state), 32'd0);
    chk("reset_chord_valid", 32'(chord_valid), 32'd0);
    chk("reset_tick_en", 32'(tick_en), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_chord", 32'(chord), 32'd0);
    rst = 1'b1;
    cyc(5);

    // Clean press of dot 1.
    key_n[0] = 1'b0;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      cyc(1);
      if (key_state[0]) seen = 1;
    end
    chk("clean_pressed", 32'(seen), 32'd1);
    chk("clean_tick_en_idle", 32'(tick_en), 32'd0);
    key_n[0] = 1'b1;
    wait_valid("clean_wait", 200);
    chk("clean_chord", 32'(chord), 32'(6'b000001));
    ack_once();
    cyc(10);

    // Bounce on dot 3, then a steady hold.
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      key_n[2] = ((c / 7) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
      if (key_state[2]) bad = 1;
    end
    chk("bounce_rejected", 32'(bad), 32'd0);
    key_n[2] = 1'b0;
    lat = 0;
    seen = 0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      cyc(1);
      if (key_state[2]) begin
        seen = 1;
        lat = c;
      end
    end
    chk("bounce_latency_ok", 32'((lat >= 33) && (lat <= 42)), 32'd1);
    key_n[2] = 1'b1;
    wait_valid("bounce_wait", 200);
    chk("bounce_chord", 32'(chord), 32'(6'b000100));
    ack_once();
    cyc(10);

    // Staggered chord: dots 1, 4, 5.
    base_rise = cv_rises;
    key_n[0] = 1'b0;
    cyc(15);
    key_n[3] = 1'b0;
    cyc(15);
    key_n[4] = 1'b0;
    cyc(60);
    key_n = '1;
    cyc(80);
    chk("stagger_one_chord", 32'(cv_rises - base_rise), 32'd1);
    chk("stagger_chord", 32'(chord), 32'(6'b011001));
    ack_once();
    cyc(10);

    // Overrun: 6'b000011 left pending, then 6'b100000 completes.
    key_n = 6'b111100;
    cyc(60);
    key_n = '1;
    cyc(80);
    chk("ovr_first_valid", 32'(chord_valid), 32'd1);
    chk("ovr_first_chord", 32'(chord), 32'(6'b000011));
    base_ovr = ovr_pulses;
    key_n = 6'b011111;
    cyc(60);
    key_n = '1;
    cyc(80);
    chk("ovr_pulse_count", 32'(ovr_pulses - base_ovr), 32'd1);
    chk("ovr_chord_kept", 32'(chord), 32'(6'b000011));
    chk("ovr_still_valid", 32'(chord_valid), 32'd1);

    // Same again, acking in the completion cycle.
    base_ovr = ovr_pulses;
    key_n = 6'b011111;
    cyc(60);
    key_n = '1;
    fired = 0;
    for (int c = 0; c < 100 && !fired; c++) begin
      cyc(1);
      if (fsm_state_dbg && key_state == '0) begin
        chord_ack = 1'b1;
        cyc(1);
        chord_ack = 1'b0;
        fired = 1;
      end
    end
    chk("ack_done_fired", 32'(fired), 32'd1);
    cyc(2);
    chk("ack_done_no_ovr", 32'(ovr_pulses - base_ovr), 32'd0);
    chk("ack_done_chord", 32'(chord), 32'(6'b100000));
    chk("ack_done_valid", 32'(chord_valid), 32'd1);
    ack_once();
    cyc(10);

    // Reset mid-gesture with dots 1 and 2 held.
    key_n = 6'b111100;
    cyc(60);
    chk("rst_pre_state", 32'(key_state), 32'(6'b000011));
    rst = 1'b0;
    cyc(1);
    chk("rst_key_state", 32'(key_state), 32'd0);
    chk("rst_chord_valid", 32'(chord_valid), 32'd0);
    chk("rst_chord", 32'(chord), 32'd0);
    chk("rst_tick_en", 32'(tick_en), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    key_n = '1;
    cyc(3);
    rst = 1'b1;
    base_rise = cv_rises;
    cyc(150);
    chk("rst_no_chord", 32'(cv_rises - base_rise), 32'd0);

    // Randomized gestures.
    for (int g = 0; g < 40; g++) rand_gesture();
    cyc(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-time bound.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/braille_key_debounce.md
# braille_key_debounce

Debounce and chord-capture stage for the six Braille dot keys. It consumes the 1 ms tick from the LFSR timeout generator and drives that generator's enable. Each key is synchronised and debounced against a millisecond count. The block reports one 6-bit dot pattern (chord) per press-and-release gesture to the trainer's character-compare logic through a valid/ack handshake.

## Interface
Parameters:
- NKEYS, 6, number of key channels (Braille dots 1–6, bit 0 = dot 1)
- DEB_MS, 20, consecutive 1 ms ticks a changed level must persist before acceptance (legal 2–31)
- CNT_W, 5, per-channel counter width; must satisfy 2^CNT_W > DEB_MS

Ports:
- Reset is `rst`: synchronous, active-low. Clock is `clk`.
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- key_n  in  NKEYS  raw asynchronous key inputs, active-low (0 = pressed)
- tick_1ms  in  1  one-cycle pulse every 1 ms from the LFSR timer
- tick_en  out  1  enable to the LFSR timer
- key_state  out  NKEYS  debounced key levels, 1 = held
- chord  out  NKEYS  captured dot pattern, valid while chord_valid = 1
- chord_valid  out  1  chord available, held until acknowledged
- chord_ack  in  1  consumer accepts chord
- overrun  out  1  one-cycle pulse: a chord completed while the previous one was still pending

## Operation
Per channel:
- A 2-flop synchroniser inverts key_n, giving sync = 1 when pressed.
- `stable` drives key_state[i]. `cnt` is CNT_W bits wide.
- If sync == stable: cnt <= 0. This takes priority over a coincident tick.
- Else, on tick_1ms: if cnt == DEB_MS-1, then stable <= sync and cnt <= 0; otherwise cnt <= cnt+1.
- Any bounce back to the old level clears cnt. Acceptance therefore requires DEB_MS uninterrupted ticks.
- tick_en is high in any cycle where any channel has sync != stable, otherwise low.

Chord FSM (states IDLE, COLLECT):
- IDLE: accum = 0. If key_state != 0, go to COLLECT with accum <= key_state.
- COLLECT: accum <= accum | key_state every cycle. When key_state == 0, go to IDLE and raise a completion event carrying accum.

Completion event handling:
- If chord_valid == 0 or chord_ack == 1 in the same cycle: chord <= accum and chord_valid <= 1.
- Otherwise chord is unchanged, the new chord is dropped, and overrun pulses for one cycle.

Handshake:
- chord_ack with chord_valid == 1 and no completion event clears chord_valid next cycle.
- chord_ack while chord_valid == 0 is ignored.

## Timing
- Reset values:
  - key_state = 0, chord = 0, chord_valid = 0, overrun = 0, tick_en = 0.
  - Synchroniser flops = 0 (released), cnt = 0, FSM = IDLE, accum = 0.
- Reset applied mid-gesture discards accum and any pending chord. No chord is reported for that gesture.
- Press latency: 2 cycles of synchronisation, then DEB_MS ticks. Because the first tick phase is arbitrary, this is (DEB_MS-1, DEB_MS] ms plus 3 clk cycles.
- key_state updates 1 cycle after the accepting tick.
- tick_en asserts 3 cycles after a raw key edge, measured at the synchroniser output plus the register stage.
- tick_en deasserts 1 cycle after the last channel resolves.
- FSM state and the completion event are registered. chord_valid rises 1 cycle after key_state returns to 0.
- Keys debounced on the same tick all land in the same cycle. Staggered presses accumulate into one chord as long as key_state never returns to all-zero in between.

## Structure
- Shared package braille_pkg holds:
  - the DEB_MS default constant
  - the chord FSM state enum (IDLE, COLLECT)
  - the NKEYS = 6 constant used by downstream compare logic
- Sub-module key_debounce_ch: one channel (synchroniser, counter, stable, mismatch flag). It is instantiated NKEYS times by generate. The top ORs the mismatch flags into tick_en.

## Test plan
All scenarios use DEB_MS = 4 and a tick every 10 clk cycles.
- Clean press: key_n[0] = 0 held for 60 cycles, then released.
  - key_state[0] rises after the 4th tick following the synchroniser; falls 4 ticks after release.
  - chord = 6'b000001 and chord_valid = 1 one cycle later.
  - tick_en is high only during the two debounce windows.
- Bounce: key_n[2] toggles every 7 cycles for 50 cycles, then holds 0.
  - key_state[2] stays 0 throughout the bounce.
  - key_state[2] rises exactly 4 ticks after the bouncing stops.
- Staggered chord: dots 1, 4 and 5 pressed 15 cycles apart, released together.
  - One chord = 6'b011001.
  - No intermediate chord_valid.
- Handshake and overrun: complete chord 6'b000011 with no ack, then complete 6'b100000.
  - chord stays 6'b000011 and overrun pulses once.
  - Repeat with chord_ack asserted in the completion cycle: chord becomes 6'b100000 and chord_valid stays high.
- Reset: rst = 0 asserted while keys 0 and 1 are held in COLLECT.
  - All outputs return to 0 next cycle.
  - After release, no chord is reported.
